// File: rtl/dm_resp.sv
// dm_resp: word-addressed memory behind a valid/ready request/response handshake with
// WAIT_CYCLES wait states. Define DM_RESP_ALIGN_CHK_EN to reject misaligned requests.
module dm_resp #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] mem_q [DEPTH];

  logic          accept_d;
  logic          access_d;
  logic          acc_we_d;
  logic          err_d;
  logic [31:0]   acc_addr_d;
  logic [31:0]   acc_wdata_d;
  logic [31:0]   acc_rdata_d;
  logic [3:0]    acc_be_d;
  logic [AW-1:0] idx_d;
  logic          unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  assign accept_d = (state_q == ST_IDLE) && req_valid && req_ready_q;

  // With zero wait states the access happens on the acceptance edge, so it uses the live request.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we_d    = req_we;
      acc_addr_d  = req_addr;
      acc_wdata_d = req_wdata;
      acc_be_d    = req_be;
      access_d    = accept_d && (WAIT_CYCLES == 0);
    end else begin
      acc_we_d    = we_q;
      acc_addr_d  = addr_q;
      acc_wdata_d = wdata_q;
      acc_be_d    = be_q;
      access_d    = (state_q == ST_WAIT) && (cnt_q == 4'd1);
    end
  end

  assign idx_d = acc_addr_d[AW+1:2];

`ifdef DM_RESP_ALIGN_CHK_EN
  assign err_d = (acc_addr_d[1:0] != 2'b00);
`else
  assign err_d = 1'b0;
`endif

  assign acc_rdata_d      = (acc_we_d || err_d) ? 32'd0 : mem_q[idx_d];
  assign unused_addr_bits = ^{acc_addr_d[31:AW+2], acc_addr_d[1:0]};

  // Memory write port; a reset on the access edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && access_d && acc_we_d && !err_d) begin
      mem_q[idx_d] <= merge_bytes(mem_q[idx_d], acc_wdata_d, acc_be_d);
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= 4'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= acc_rdata_d;
              rsp_err_q   <= err_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= acc_rdata_d;
            rsp_err_q   <= err_d;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_resp.sv
// Directed table-driven bench for dm_resp: a WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance.
module tb_dm_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_we, z_rsp_ready;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_resp #(.WAIT_CYCLES(2), .DEPTH(1024)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dm_resp #(.WAIT_CYCLES(0), .DEPTH(1024)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance; lat counts cycles from accept to rsp_valid.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    logic got;
    @(negedge clk);
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;
    logic        got;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_req_be = 4'd0;
    z_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_z_req_ready", {31'd0, z_req_ready}, 32'd1);
    rst = 1'b0;

    add(1'b1, 32'h10,   32'h12345678, 4'b1111, 32'h0,        1'b0);
    add(1'b0, 32'h10,   32'h0,        4'b0000, 32'h12345678, 1'b0);
    add(1'b1, 32'h10,   32'hFFFFFFFF, 4'b1111, 32'h0,        1'b0);
    add(1'b1, 32'h10,   32'h000000AB, 4'b0001, 32'h0,        1'b0);
    add(1'b0, 32'h10,   32'h0,        4'b1111, 32'hFFFFFFAB, 1'b0);
    add(1'b1, 32'h30,   32'h0,        4'b1111, 32'h0,        1'b0);
    add(1'b1, 32'h30,   32'hAABBCCDD, 4'b1010, 32'h0,        1'b0);
    add(1'b0, 32'h30,   32'h5A5A5A5A, 4'b0000, 32'hAA00CC00, 1'b0);
    add(1'b1, 32'h1010, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0);
    add(1'b0, 32'h0010, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
    add(1'b1, 32'h10,   32'h11111111, 4'b0000, 32'h0,        1'b0);
    add(1'b0, 32'hFFFF_F010, 32'h0,   4'b0000, 32'hDEADBEEF, 1'b0);
    add(1'b1, 32'h20,   32'h01020304, 4'b1111, 32'h0,        1'b0);
`ifdef DM_RESP_ALIGN_CHK_EN
    add(1'b1, 32'h22,   32'h99887766, 4'b1111, 32'h0,        1'b1);
    add(1'b0, 32'h20,   32'h0,        4'b0000, 32'h01020304, 1'b0);
    add(1'b0, 32'h23,   32'h0,        4'b0000, 32'h0,        1'b1);
`else
    add(1'b1, 32'h22,   32'h99887766, 4'b1111, 32'h0,        1'b0);
    add(1'b0, 32'h20,   32'h0,        4'b0000, 32'h99887766, 1'b0);
    add(1'b0, 32'h23,   32'h0,        4'b0000, 32'h99887766, 1'b0);
`endif

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // Back-pressure: response must hold for 5 cycles while rsp_ready stays low.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'b0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    chk("stall_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("stall%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_rdata", k), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("stall_release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("stall_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset while a store is in flight, one and two cycles after acceptance.
    for (int d = 1; d <= 2; d++) begin
      txn(1'b1, 32'h50, 32'hCAFEF00D, 4'b1111, rd, er, lat);
      chk($sformatf("rstwait%0d_prestore_rdata", d), rd, 32'h0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'h00000055; req_be = 4'b1111;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk($sformatf("rstwait%0d_accepted", d), {31'd0, req_ready}, 32'd0);
      repeat (d) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk($sformatf("rstwait%0d_req_ready", d), {31'd0, req_ready}, 32'd1);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk($sformatf("rstwait%0d_no_response", d), 32'(seen), 32'd0);
      txn(1'b0, 32'h50, 32'h0, 4'b0000, rd, er, lat);
      chk($sformatf("rstwait%0d_mem_kept", d), rd, 32'hCAFEF00D);
    end

    // Zero-wait-state instance: response one cycle after acceptance, with address wrap.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("z%0d_req_ready", i), {31'd0, z_req_ready}, 32'd1);
      z_req_valid = 1'b1;
      z_req_we    = (i == 0);
      z_req_addr  = (i == 0) ? 32'h1010 : 32'h0010;
      z_req_wdata = 32'hDEADBEEF;
      z_req_be    = 4'b1111;
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        lat++;
        if (z_rsp_valid) got = 1'b1;
      end
      chk($sformatf("z%0d_latency", i), 32'(lat), 32'd1);
      chk($sformatf("z%0d_rdata", i), z_rsp_rdata, (i == 0) ? 32'h0 : 32'hDEADBEEF);
      z_rsp_ready = 1'b1;
      @(posedge clk); #1;
      z_rsp_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
